// File: rtl/memoria_cache.sv
// 2-way set-associative write-back cache (4 sets) with a 32 x 3-bit backing memory.
// A miss walks COMPARE -> [WRITEBACK ->] ALLOCATE and then hits on the re-evaluated request.
module memoria_cache (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wren,
    input  logic [2:0] data,
    input  logic [4:0] address,
    output logic       hit,
    output logic       valid,
    output logic       LRU,
    output logic       dirty,
    output logic       writeBack,
    output logic [2:0] tag,
    output logic [2:0] dadoParaCPU
);

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t     state;
    state_t     state_next;

    // Line storage indexed [way][set]; lru[set] names the next victim way.
    logic       line_v   [0:1][0:3];
    logic       line_d   [0:1][0:3];
    logic [2:0] line_t   [0:1][0:3];
    logic [2:0] line_dat [0:1][0:3];
    logic       lru      [0:3];
    logic [2:0] mem      [0:31];

    logic [4:0] lat_addr;
    logic       vic_way;

    logic [1:0] idx;
    logic [2:0] atag;
    logic [1:0] lidx;
    logic       hit0;
    logic       hit1;
    logic       is_hit;
    logic       hit_way;
    logic       miss_way;
    logic       vic_dirty;

    always_comb begin
        idx       = address[1:0];
        atag      = address[4:2];
        lidx      = lat_addr[1:0];
        hit0      = line_v[0][idx] && (line_t[0][idx] == atag);
        hit1      = line_v[1][idx] && (line_t[1][idx] == atag);
        is_hit    = hit0 || hit1;
        hit_way   = !hit0;
        miss_way  = !line_v[0][idx] ? 1'b0 :
                    !line_v[1][idx] ? 1'b1 : lru[idx];
        vic_dirty = line_v[miss_way][idx] && line_d[miss_way][idx];
    end

    always_comb begin
        state_next = state;
        case (state)
            COMPARE: begin
                if (!is_hit) begin
                    state_next = vic_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: state_next = ALLOCATE;
            ALLOCATE:  state_next = COMPARE;
            default:   state_next = COMPARE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= COMPARE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                mem[i[4:0]] <= i[2:0];
            end
            for (int unsigned s = 0; s < 4; s++) begin
                line_v[0][s[1:0]]   <= 1'b0;
                line_v[1][s[1:0]]   <= 1'b0;
                line_d[0][s[1:0]]   <= 1'b0;
                line_d[1][s[1:0]]   <= 1'b0;
                line_t[0][s[1:0]]   <= '0;
                line_t[1][s[1:0]]   <= '0;
                line_dat[0][s[1:0]] <= '0;
                line_dat[1][s[1:0]] <= '0;
                lru[s[1:0]]         <= 1'b0;
            end
            lat_addr    <= '0;
            vic_way     <= 1'b0;
            hit         <= 1'b0;
            valid       <= 1'b0;
            LRU         <= 1'b0;
            dirty       <= 1'b0;
            writeBack   <= 1'b0;
            tag         <= '0;
            dadoParaCPU <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (is_hit) begin
                        if (wren) begin
                            line_dat[hit_way][idx] <= data;
                            line_d[hit_way][idx]   <= 1'b1;
                            dadoParaCPU            <= data;
                            dirty                  <= 1'b1;
                        end else begin
                            dadoParaCPU <= line_dat[hit_way][idx];
                            dirty       <= line_d[hit_way][idx];
                        end
                        lru[idx]  <= hit0;
                        LRU       <= hit0;
                        hit       <= 1'b1;
                        valid     <= 1'b1;
                        writeBack <= 1'b0;
                        tag       <= atag;
                    end else begin
                        lat_addr  <= address;
                        vic_way   <= miss_way;
                        hit       <= 1'b0;
                        valid     <= line_v[miss_way][idx];
                        dirty     <= line_d[miss_way][idx];
                        tag       <= line_t[miss_way][idx];
                        LRU       <= lru[idx];
                        writeBack <= vic_dirty;
                    end
                end
                WRITEBACK: begin
                    mem[{line_t[vic_way][lidx], lidx}] <= line_dat[vic_way][lidx];
                    line_d[vic_way][lidx] <= 1'b0;
                    dirty                 <= 1'b0;
                    writeBack             <= 1'b1;
                end
                ALLOCATE: begin
                    line_dat[vic_way][lidx] <= mem[lat_addr];
                    line_t[vic_way][lidx]   <= lat_addr[4:2];
                    line_v[vic_way][lidx]   <= 1'b1;
                    line_d[vic_way][lidx]   <= 1'b0;
                    writeBack               <= 1'b0;
                    hit                     <= 1'b0;
                end
                default: begin
                    hit <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_cache.sv
// Bench for memoria_cache: directed and random accesses against a line/set-level cache model.
module tb_memoria_cache;

    logic       clock = 1'b0;
    logic       resetn;
    logic       wren;
    logic [2:0] data;
    logic [4:0] address;
    logic       hit;
    logic       valid;
    logic       LRU;
    logic       dirty;
    logic       writeBack;
    logic [2:0] tag;
    logic [2:0] dadoParaCPU;

    int tests = 0;
    int fails = 0;

    // Model state indexed [set][way].
    bit         mv   [4][2];
    bit         md   [4][2];
    logic [2:0] mt   [4][2];
    logic [2:0] mdat [4][2];
    bit         mlru [4];
    logic [2:0] mmem [32];

    memoria_cache dut (
        .clock       (clock),
        .resetn      (resetn),
        .wren        (wren),
        .data        (data),
        .address     (address),
        .hit         (hit),
        .valid       (valid),
        .LRU         (LRU),
        .dirty       (dirty),
        .writeBack   (writeBack),
        .tag         (tag),
        .dadoParaCPU (dadoParaCPU)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w]   = 1'b0;
                md[s][w]   = 1'b0;
                mt[s][w]   = 3'b000;
                mdat[s][w] = 3'b000;
            end
            mlru[s] = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            mmem[i] = 3'(i);
        end
    endtask

    // One CPU request held until hit; model computes victim, latency and final outputs.
    task automatic do_access(input logic wr, input logic [4:0] a, input logic [2:0] d, input string nm);
        int         s;
        int         w;
        int         lat;
        int         exp_lat;
        bit         wbseen;
        logic [2:0] tg;
        logic [6:0] got_m;
        logic [6:0] exp_m;
        logic [10:0] got_h;
        logic [10:0] exp_h;
        s  = int'(a[1:0]);
        tg = a[4:2];
        w  = -1;
        for (int k = 0; k < 2; k++) begin
            if (w < 0 && mv[s][k] && mt[s][k] == tg) w = k;
        end
        wren    = wr;
        address = a;
        data    = d;
        @(posedge clock);
        #1;
        if (w < 0) begin
            w = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : int'(mlru[s]));
            exp_m = {1'b0, mv[s][w], md[s][w], mt[s][w], mv[s][w] & md[s][w]};
            got_m = {hit, valid, dirty, tag, writeBack};
            tests++;
            if (got_m !== exp_m) begin
                fails++;
                $display("FAIL %s miss_outputs {hit,valid,dirty,tag,wb}: got %b expected %b", nm, got_m, exp_m);
            end
            exp_lat = (mv[s][w] && md[s][w]) ? 3 : 2;
            if (mv[s][w] && md[s][w]) mmem[{mt[s][w], a[1:0]}] = mdat[s][w];
            mdat[s][w] = mmem[a];
            mt[s][w]   = tg;
            mv[s][w]   = 1'b1;
            md[s][w]   = 1'b0;
            lat    = 0;
            wbseen = (writeBack === 1'b1);
            while (hit !== 1'b1 && lat < 8) begin
                @(posedge clock);
                #1;
                lat++;
                if (writeBack === 1'b1 && hit !== 1'b1) wbseen = 1'b1;
            end
            tests++;
            if (lat != exp_lat) begin
                fails++;
                $display("FAIL %s miss_latency: got %0d edges expected %0d", nm, lat, exp_lat);
            end
            tests++;
            if (wbseen != (exp_lat == 3)) begin
                fails++;
                $display("FAIL %s writeback_pulse: got %0b expected %0b", nm, wbseen, exp_lat == 3);
            end
        end
        if (wr) begin
            mdat[s][w] = d;
            md[s][w]   = 1'b1;
        end
        mlru[s] = (w == 0);
        exp_h = {1'b1, 1'b1, md[s][w], tg, 1'b0, mlru[s], mdat[s][w]};
        got_h = {hit, valid, dirty, tag, writeBack, LRU, dadoParaCPU};
        tests++;
        if (got_h !== exp_h) begin
            fails++;
            $display("FAIL %s hit_outputs {hit,valid,dirty,tag,wb,LRU,dado}: got %b expected %b", nm, got_h, exp_h);
        end
    endtask

    task automatic apply_reset();
        resetn  = 1'b0;
        wren    = 1'b0;
        data    = 3'b000;
        address = 5'b00000;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [10:0] got;
        apply_reset();
        got = {hit, valid, LRU, dirty, writeBack, tag, dadoParaCPU};
        tests++;
        if (got !== 11'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b", got, 11'b0);
        end
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        do_access(1'b0, 5'b10000, 3'b000, "rd_10000");
        do_access(1'b0, 5'b00001, 3'b000, "rd_00001");
        do_access(1'b1, 5'b00001, 3'b101, "wr_00001");
        do_access(1'b1, 5'b01001, 3'b100, "wr_01001");
        do_access(1'b0, 5'b00101, 3'b000, "rd_00101");
        do_access(1'b1, 5'b01101, 3'b001, "wr_01101");
        do_access(1'b0, 5'b00001, 3'b000, "rd_00001_again");
        do_access(1'b0, 5'b01001, 3'b000, "rd_01001");
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 5'b11110, 3'b000, "b2b_fill");
        for (int i = 0; i < 6; i++) begin
            do_access(i[0], 5'b11110, 3'(i + 2), "b2b_hit");
        end
        do_access(1'b0, 5'b00010, 3'b000, "b2b_other_way");
        do_access(1'b0, 5'b11110, 3'b000, "b2b_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            do_access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      3'($urandom_range(0, 7)), "random");
        end
    endtask

    task automatic test_reset_mid_writeback();
        logic [10:0] got;
        test_reset();
        do_access(1'b1, 5'b00010, 3'b111, "mid_wb_fill0");
        do_access(1'b1, 5'b00110, 3'b110, "mid_wb_fill1");
        wren    = 1'b0;
        address = 5'b01010;
        data    = 3'b000;
        @(posedge clock);
        #1;
        tests++;
        if ({hit, writeBack} !== 2'b01) begin
            fails++;
            $display("FAIL mid_wb_entry {hit,wb}: got %b expected %b", {hit, writeBack}, 2'b01);
        end
        resetn = 1'b0;
        @(posedge clock);
        #1;
        got = {hit, valid, LRU, dirty, writeBack, tag, dadoParaCPU};
        tests++;
        if (got !== 11'b0) begin
            fails++;
            $display("FAIL mid_wb_reset_outputs: got %b expected %b", got, 11'b0);
        end
        model_reset();
        resetn = 1'b1;
        do_access(1'b0, 5'b00010, 3'b000, "after_abort_rd_00010");
        do_access(1'b0, 5'b01010, 3'b000, "after_abort_rd_01010");
        do_access(1'b0, 5'b00110, 3'b000, "after_abort_rd_00110");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_writeback();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
